// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared constants for the 5-stage MIPS core (control layout,
//            instruction field positions)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int CTRL_W = 9;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_ALUOP    = 7;   // two bits: [CTRL_ALUOP+1:CTRL_ALUOP]

  localparam int INSTR_RS_LSB = 21;
  localparam int INSTR_RT_LSB = 16;
  localparam int INSTR_RD_LSB = 11;
  localparam int REG_IDX_W    = 5;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
//------------------------------------------------------------------------------
// load_use_detect : combinational load-use hazard check between EX and ID
// Revision        : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_use_detect (
  input  logic        ex_mem_read,
  input  logic [31:0] ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_flush,
  output logic        stall
);

  logic [31:0] id_rs_ext;
  logic [31:0] id_rt_ext;

  assign id_rs_ext = {27'd0, id_rs};
  assign id_rt_ext = {27'd0, id_rt};

  // A pending flush already discards the ID instruction, so no stall is needed.
  assign stall = ex_mem_read && (ex_rt != 32'd0) &&
                 ((ex_rt == id_rs_ext) || (ex_rt == id_rt_ext)) && !id_flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with load-use stall / bubble insertion.
//               Optional stall counter enabled by defining STALL_COUNT_EN.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IF_ID_Instr,
  input  logic [31:0]       ID_RegData1,
  input  logic [31:0]       ID_RegData2,
  input  logic [31:0]       ID_SignExt,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              ID_Flush,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              Stall,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic [31:0]       ID_EX_Data1,
  output logic [31:0]       ID_EX_Data2,
  output logic [31:0]       ID_EX_Imm,
  output logic [31:0]       ID_EX_Rs,
  output logic [31:0]       ID_EX_Rt,
  output logic [31:0]       ID_EX_Rd
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]       StallCount
`endif
);

  import mips_pkg::*;

  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              stall;

  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
  logic [31:0]       data1_d, data1_q;
  logic [31:0]       data2_d, data2_q;
  logic [31:0]       imm_d,   imm_q;
  logic [4:0]        rs_d,    rs_q;
  logic [4:0]        rt_d,    rt_q;
  logic [4:0]        rd_d,    rd_q;

  logic              unused_instr_bits;

  assign id_rs = IF_ID_Instr[INSTR_RS_LSB +: REG_IDX_W];
  assign id_rt = IF_ID_Instr[INSTR_RT_LSB +: REG_IDX_W];
  assign id_rd = IF_ID_Instr[INSTR_RD_LSB +: REG_IDX_W];
  assign unused_instr_bits = ^{IF_ID_Instr[31:26], IF_ID_Instr[10:0]};

  load_use_detect u_load_use_detect (
    .ex_mem_read (ID_EX_MemRead),
    .ex_rt       (ID_EX_Rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_flush    (ID_Flush),
    .stall       (stall)
  );

  assign Stall       = stall;
  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;

  // Flush and stall both load an all-zero bubble, indices included, so the
  // forwarding unit never matches on it.
  always_comb begin
    ctrl_d  = ID_Ctrl;
    data1_d = ID_RegData1;
    data2_d = ID_RegData2;
    imm_d   = ID_SignExt;
    rs_d    = id_rs;
    rt_d    = id_rt;
    rd_d    = id_rd;
    if (ID_Flush || stall) begin
      ctrl_d  = '0;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign ID_EX_Ctrl     = ctrl_q;
  assign ID_EX_RegWrite = ctrl_q[CTRL_REGWRITE];
  assign ID_EX_MemRead  = ctrl_q[CTRL_MEMREAD];
  assign ID_EX_Data1    = data1_q;
  assign ID_EX_Data2    = data2_q;
  assign ID_EX_Imm      = imm_q;
  assign ID_EX_Rs       = {27'd0, rs_q};
  assign ID_EX_Rt       = {27'd0, rt_q};
  assign ID_EX_Rd       = {27'd0, rd_q};

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage MIPS core, combined with load-use hazard detection. It captures decoded operands, immediate, register indices and the control bundle from ID. It supplies the EX stage and the forwarding unit (ID_EX_Rs/Rt/Rd, 32-bit zero-extended). It stalls PC and IF/ID for one cycle and inserts a bubble when an instruction in ID needs a value that an EX-stage load has not yet produced.

## Interface
Parameters:
- CTRL_W, 9: width of the control bundle. Bit positions are defined in the package.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- IF_ID_Instr  in  32  instruction in ID. Fields: rs=[25:21], rt=[20:16], rd=[15:11]
- ID_RegData1  in  32  register file read port 1
- ID_RegData2  in  32  register file read port 2
- ID_SignExt  in  32  sign-extended immediate
- ID_Ctrl  in  CTRL_W  control bundle from the main decoder
- ID_Flush  in  1  from the branch/jump resolution logic: load a bubble into ID/EX
- PCWrite  out  1  PC enable
- IF_ID_Write  out  1  IF/ID register enable
- Stall  out  1  load-use stall active this cycle
- ID_EX_Ctrl  out  CTRL_W  registered control bundle
- ID_EX_RegWrite, ID_EX_MemRead  out  1 each  registered bits taken from ID_EX_Ctrl
- ID_EX_Data1, ID_EX_Data2, ID_EX_Imm  out  32 each  registered operands and immediate
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  out  32 each  registered 5-bit indices, zero-extended
- StallCount  out  32  only when STALL_COUNT_EN is defined

## Operation
- Stall is combinational:
  - Stall = ID_EX_MemRead && ID_EX_Rt != 0 && (ID_EX_Rt == IF_ID_Instr[25:21] || ID_EX_Rt == IF_ID_Instr[20:16]) && !ID_Flush.
  - Compare the zero-extended registered index against the 5-bit field.
- PCWrite = !Stall. IF_ID_Write = !Stall.
- On each clock edge, ID/EX loads one of the following, highest priority first:
  1. rst: all fields 0.
  2. ID_Flush: bubble.
  3. Stall: bubble.
  4. Otherwise: ID inputs.
- Bubble: every ID/EX field is 0, including indices and data. A bubble never writes, never loads and never matches in forwarding.
- After a bubble, ID_EX_MemRead = 0, so Stall drops by itself. Every load-use stall lasts exactly 1 cycle.
- A load to $0 never stalls.
- Simultaneous stall condition and ID_Flush:
  - Flush wins.
  - PCWrite = 1, IF_ID_Write = 1.
  - Stall = 0, and the event is not counted.
- No handshakes. The stage is always ready. Stalls originate only here.

## Timing
- Register latency: 1 cycle from ID inputs to ID_EX_* outputs.
- Stall, PCWrite and IF_ID_Write are valid in the same cycle. They depend on current ID_EX_* state and IF_ID_Instr.
- Reset values:
  - All ID_EX_* outputs = 0.
  - Stall = 0, PCWrite = 1, IF_ID_Write = 1.
  - StallCount = 0.
- Reset asserted mid-stall: the next edge clears ID/EX. Stall = 0 from the cycle after that edge.
- Hold rst for at least 1 cycle. Outputs are valid from the first edge with rst = 1.

## Configuration
- STALL_COUNT_EN defined:
  - 32-bit StallCount port exists.
  - It increments on each edge where Stall = 1.
  - It saturates at 32'hFFFFFFFF and is cleared by rst.
- STALL_COUNT_EN undefined: the counter and the port are absent. All other behaviour is identical.

## Structure
- Shared package mips_pkg holds:
  - CTRL_W.
  - Control-bit index constants: CTRL_REGWRITE, CTRL_MEMTOREG, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_BRANCH, CTRL_REGDST, CTRL_ALUSRC, CTRL_ALUOP (2 bits).
  - Instruction field position constants.
- One sub-module: load_use_detect.
  - Combinational Stall equation.
  - Instantiated once.
  - Reused by the verification model.

## Test plan
- Reset: rst high 2 cycles with arbitrary inputs.
  - Required: all ID_EX_* = 0, Stall = 0, PCWrite = 1, StallCount = 0.
- lw $9,0($8) followed by add $10,$9,$11:
  - Cycle after lw latches: Stall = 1, PCWrite = 0, IF_ID_Write = 0.
  - Next edge: ID_EX_Ctrl = 0.
  - Following edge: add latched with ID_EX_Rs = 9, ID_EX_Rt = 11, ID_EX_Rd = 10.
- lw $9 then sub $12,$13,$9 (rt match): 1-cycle stall.
- lw $9 then add $12,$13,$14: no stall.
- lw $0,4($8) then add $1,$0,$0: Stall stays 0 throughout.
- lw $9 then dependent add with ID_Flush = 1 in the stall cycle:
  - Same cycle: Stall = 0, PCWrite = 1.
  - Next edge: ID/EX holds a bubble.
  - StallCount unchanged.
- With STALL_COUNT_EN: three independent load-use pairs.
  - Required: StallCount = 3.
  - Then assert rst during a stall: StallCount = 0 and Stall = 0 after the edge.
